// File: rtl/spi_master_arbiter_if.sv
// Bundle of the requester-side and SPI-master-side signals of spi_master_arbiter.
// The master modport is the arbiter's view; slave is the environment's view.
interface spi_master_arbiter_if #(
  parameter int NREQ = 4,
  parameter int NSS  = 2
);
  logic [NREQ-1:0]     req_i;
  logic [NREQ*8-1:0]   req_data_i;
  logic [NREQ*NSS-1:0] req_ss_i;
  logic [NREQ-1:0]     ack_o;
  logic [7:0]          rsp_data_o;
  logic                rsp_err_o;
  logic [NREQ-1:0]     grant_o;
  logic                busy_o;
  logic [7:0]          m_toXmit_o;
  logic [NSS-1:0]      m_ss_o;
  logic                m_strobe_o;
  logic [7:0]          m_Rcvd_i;
  logic                m_Ready_i;
  logic                m_busy_i;

  modport master (
    input  req_i, req_data_i, req_ss_i, m_Rcvd_i, m_Ready_i, m_busy_i,
    output ack_o, rsp_data_o, rsp_err_o, grant_o, busy_o,
           m_toXmit_o, m_ss_o, m_strobe_o
  );

  modport slave (
    output req_i, req_data_i, req_ss_i, m_Rcvd_i, m_Ready_i, m_busy_i,
    input  ack_o, rsp_data_o, rsp_err_o, grant_o, busy_o,
           m_toXmit_o, m_ss_o, m_strobe_o
  );
endinterface

// File: rtl/spi_master_arbiter.sv
// Round-robin arbiter sharing one SPI master control port between NREQ requesters.
// Every output is a flop; the FSM decides next-cycle values directly.
module spi_master_arbiter #(
  parameter int NREQ    = 4,
  parameter int NSS     = 2,
  parameter int TIMEOUT = 1023,
  parameter int GAP     = 4
) (
  input logic                  Clk_i,
  input logic                  Rst_ni,
  spi_master_arbiter_if.master bus
);
  localparam int PW = $clog2(NREQ);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_STROBE, S_WAIT_BUSY, S_WAIT_DONE, S_RESP, S_GAP
  } state_t;

  state_t          r_state;
  logic [PW-1:0]   r_ptr, r_gidx;
  logic [CW-1:0]   r_cnt;
  logic [GW-1:0]   r_gcnt;
  logic [7:0]      r_rdata;
  logic            r_err;

  logic [PW-1:0]   w_win;
  logic            w_found;
  logic [7:0]      w_data;
  logic [NSS-1:0]  w_ss;

  // First asserted request at or after ptr, wrapping.
  always_comb begin
    w_win   = '0;
    w_found = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!w_found && bus.req_i[PW'((int'(r_ptr) + i) % NREQ)]) begin
        w_win   = PW'((int'(r_ptr) + i) % NREQ);
        w_found = 1'b1;
      end
    end
  end

  assign w_data = bus.req_data_i[int'(w_win)*8 +: 8];
  assign w_ss   = bus.req_ss_i[int'(w_win)*NSS +: NSS];

  always_ff @(posedge Clk_i or negedge Rst_ni) begin
    if (!Rst_ni) begin
      r_state        <= S_IDLE;
      r_ptr          <= '0;
      r_gidx         <= '0;
      r_cnt          <= '0;
      r_gcnt         <= '0;
      r_rdata        <= '0;
      r_err          <= 1'b0;
      bus.ack_o      <= '0;
      bus.rsp_data_o <= '0;
      bus.rsp_err_o  <= 1'b0;
      bus.grant_o    <= '0;
      bus.busy_o     <= 1'b0;
      bus.m_toXmit_o <= '0;
      bus.m_ss_o     <= '0;
      bus.m_strobe_o <= 1'b0;
    end else begin
      bus.ack_o      <= '0;
      bus.rsp_data_o <= '0;
      bus.rsp_err_o  <= 1'b0;
      bus.m_strobe_o <= 1'b0;
      case (r_state)
        S_IDLE: if (w_found) begin
          bus.m_toXmit_o <= w_data;
          bus.m_ss_o     <= w_ss;
          bus.grant_o    <= NREQ'(1) << w_win;
          bus.busy_o     <= 1'b1;
          r_gidx         <= w_win;
          // A bad select never reaches the master; fail it straight away.
          if (!$onehot(w_ss)) begin
            r_rdata <= '0;
            r_err   <= 1'b1;
            r_state <= S_RESP;
          end else begin
            r_state <= S_STROBE;
          end
        end
        S_STROBE: begin
          bus.m_strobe_o <= 1'b1;
          r_cnt          <= '0;
          r_state        <= S_WAIT_BUSY;
        end
        S_WAIT_BUSY: begin
          if (bus.m_busy_i) begin
            r_cnt   <= '0;
            r_state <= S_WAIT_DONE;
          end else if (r_cnt == CW'(TIMEOUT)) begin
            r_rdata <= '0;
            r_err   <= 1'b1;
            r_state <= S_RESP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_WAIT_DONE: begin
          if (!bus.m_busy_i && bus.m_Ready_i) begin
            r_rdata <= bus.m_Rcvd_i;
            r_err   <= 1'b0;
            r_state <= S_RESP;
          end else if (r_cnt == CW'(TIMEOUT)) begin
            r_rdata <= '0;
            r_err   <= 1'b1;
            r_state <= S_RESP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_RESP: begin
          bus.ack_o      <= NREQ'(1) << r_gidx;
          bus.rsp_data_o <= r_rdata;
          bus.rsp_err_o  <= r_err;
          r_ptr          <= (int'(r_gidx) == NREQ - 1) ? '0 : r_gidx + 1'b1;
          bus.m_ss_o     <= '0;
          bus.grant_o    <= '0;
          r_gcnt         <= '0;
          if (GAP > 0) begin
            r_state <= S_GAP;
          end else begin
            bus.busy_o <= 1'b0;
            r_state    <= S_IDLE;
          end
        end
        S_GAP: begin
          if (r_gcnt == GW'(GAP - 1)) begin
            bus.busy_o <= 1'b0;
            r_state    <= S_IDLE;
          end else begin
            r_gcnt <= r_gcnt + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_master_arbiter.sv
// Directed bench for spi_master_arbiter with a simple SPI master model that
// can echo, return a fixed byte, or never go busy.
module tb_spi_master_arbiter;
  localparam int NREQ = 4, NSS = 2, TO = 16, GP = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  spi_master_arbiter_if #(.NREQ(NREQ), .NSS(NSS)) bus ();
  spi_master_arbiter #(.NREQ(NREQ), .NSS(NSS), .TIMEOUT(TO), .GAP(GP)) dut (
    .Clk_i(clk), .Rst_ni(rst_n), .bus(bus)
  );

  int checks = 0, errors = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Master model: mode 0 echo, 1 fixed byte, 2 never busy.
  int mode = 0;
  logic [7:0] fixed_b = 8'h3C;
  int mcnt = 0;
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcnt = 0;
      bus.m_busy_i = 1'b0; bus.m_Ready_i = 1'b0; bus.m_Rcvd_i = 8'h00;
    end else begin
      if (mcnt == 0) begin
        if (bus.m_strobe_o && mode != 2) mcnt = 1;
      end else mcnt++;
      bus.m_busy_i  = (mcnt >= 2 && mcnt < 10);
      bus.m_Ready_i = (mcnt == 10);
      if (mcnt == 10) bus.m_Rcvd_i = (mode == 1) ? fixed_b : bus.m_toXmit_o;
      if (mcnt >= 11) mcnt = 0;
    end
  end

  typedef struct {
    int k; logic [7:0] d; logic [1:0] ss; int mode;
    logic [3:0] eack; logic [7:0] edata; logic eerr; int elat; int estrb;
  } vec_t;
  vec_t tv[6];

  task automatic wait_idle();
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (!bus.busy_o) return;
    end
    chk("idle_timeout", 1, 0);
  endtask

  task automatic xfer(input int k, input logic [7:0] d, input logic [1:0] ss,
                      output logic [3:0] ack, output logic [7:0] rd, output logic rerr,
                      output int lat, output int nstrb, output logic held_ok);
    int g;
    g = -1; ack = '0; rd = '0; rerr = 1'b0; lat = -1; nstrb = 0; held_ok = 1'b1;
    @(negedge clk);
    bus.req_data_i[k*8 +: 8] = d;
    bus.req_ss_i[k*2 +: 2]   = ss;
    bus.req_i[k]             = 1'b1;
    for (int t = 0; t < 200; t++) begin
      @(posedge clk); #1;
      if (bus.m_strobe_o) nstrb++;
      if (bus.grant_o != '0) begin
        if (g < 0) g = t;
        if (bus.m_ss_o !== ss || bus.m_toXmit_o !== d) held_ok = 1'b0;
      end
      if (bus.ack_o != '0) begin
        ack = bus.ack_o; rd = bus.rsp_data_o; rerr = bus.rsp_err_o; lat = t - g;
        break;
      end
    end
    bus.req_i[k] = 1'b0;
    wait_idle();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
  endtask

  logic [3:0] a; logic [7:0] rd; logic re; int lat, ns; logic hok;
  int n, nidle; logic ssbad; bit got;

  initial begin
    tv[0] = '{2, 8'hA5, 2'b10, 1, 4'b0100, 8'h3C, 1'b0, 12, 1};
    tv[1] = '{1, 8'h11, 2'b00, 0, 4'b0010, 8'h00, 1'b1, 1, 0};
    tv[2] = '{1, 8'h22, 2'b11, 0, 4'b0010, 8'h00, 1'b1, 1, 0};
    tv[3] = '{0, 8'h5A, 2'b01, 2, 4'b0001, 8'h00, 1'b1, TO+3, 1};
    tv[4] = '{3, 8'hC3, 2'b01, 0, 4'b1000, 8'hC3, 1'b0, 12, 1};
    tv[5] = '{1, 8'h6E, 2'b10, 0, 4'b0010, 8'h6E, 1'b0, 12, 1};

    bus.req_i = '0; bus.req_data_i = '0; bus.req_ss_i = '0;
    rst_n = 1'b0;
    #1;
    chk("rst_outputs", {bus.grant_o, bus.busy_o, bus.m_ss_o, bus.m_strobe_o,
        bus.m_toXmit_o, bus.ack_o, bus.rsp_data_o, bus.rsp_err_o}, 0);
    do_reset();
    @(posedge clk); #1;
    chk("post_rst_idle", {bus.grant_o, bus.busy_o, bus.m_ss_o, bus.m_strobe_o, bus.ack_o}, 0);

    foreach (tv[i]) begin
      mode = tv[i].mode;
      xfer(tv[i].k, tv[i].d, tv[i].ss, a, rd, re, lat, ns, hok);
      chk($sformatf("v%0d_ack", i), a, tv[i].eack);
      chk($sformatf("v%0d_data", i), rd, tv[i].edata);
      chk($sformatf("v%0d_err", i), re, tv[i].eerr);
      chk($sformatf("v%0d_lat", i), lat, tv[i].elat);
      chk($sformatf("v%0d_strobes", i), ns, tv[i].estrb);
      chk($sformatf("v%0d_held", i), hok, 1'b1);
    end

    // Round robin with all requesters asserted from a fresh pointer.
    mode = 0;
    do_reset();
    @(negedge clk);
    for (int k = 0; k < NREQ; k++) begin
      bus.req_data_i[k*8 +: 8] = 8'(8'h10 + k);
      bus.req_ss_i[k*2 +: 2]   = 2'b01;
    end
    bus.req_i = 4'hF;
    n = 0; nidle = -1; ssbad = 1'b0;
    for (int t = 0; t < 600 && n < 8; t++) begin
      @(posedge clk); #1;
      if (bus.ack_o != '0) begin
        chk($sformatf("rr%0d_ack", n), bus.ack_o, 4'b0001 << (n % 4));
        chk($sformatf("rr%0d_data", n), bus.rsp_data_o, 8'h10 + (n % 4));
        n++; nidle = 0;
      end else if (nidle >= 0) begin
        if (bus.grant_o == '0) begin
          nidle++;
          if (bus.m_ss_o != '0) ssbad = 1'b1;
        end else begin
          chk($sformatf("rr_gap%0d", n), nidle, GP);
          nidle = -1;
        end
      end
    end
    chk("rr_count", n, 8);
    chk("rr_gap_ss_zero", ssbad, 1'b0);
    bus.req_i = '0;
    wait_idle();

    // Requester 0 drops its request one cycle after being granted.
    @(negedge clk);
    bus.req_data_i[7:0] = 8'h99; bus.req_ss_i[1:0] = 2'b10; bus.req_i[0] = 1'b1;
    got = 1'b0; a = '0; rd = '0;
    for (int t = 0; t < 50; t++) begin
      @(posedge clk); #1;
      if (bus.grant_o != '0) begin got = 1'b1; break; end
    end
    chk("drop_granted", got, 1'b1);
    @(posedge clk); #1; bus.req_i[0] = 1'b0;
    for (int t = 0; t < 100; t++) begin
      @(posedge clk); #1;
      if (bus.ack_o != '0) begin a = bus.ack_o; rd = bus.rsp_data_o; break; end
    end
    chk("drop_ack", a, 4'b0001);
    chk("drop_data", rd, 8'h99);
    wait_idle();

    // Reset while waiting for completion; pointer currently points past 0.
    @(negedge clk);
    bus.req_data_i[23:16] = 8'h42; bus.req_ss_i[5:4] = 2'b01; bus.req_i[2] = 1'b1;
    got = 1'b0;
    for (int t = 0; t < 50; t++) begin
      @(posedge clk); #1;
      if (bus.m_busy_i && bus.grant_o != '0) begin got = 1'b1; break; end
    end
    chk("mid_in_wait_done", got, 1'b1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_async", {bus.grant_o, bus.busy_o, bus.m_ss_o, bus.m_strobe_o,
        bus.m_toXmit_o, bus.ack_o, bus.rsp_data_o, bus.rsp_err_o}, 0);
    bus.req_data_i[7:0] = 8'h24; bus.req_ss_i[1:0] = 2'b01;
    bus.req_i = 4'b0101;
    repeat (2) begin
      @(posedge clk); #1;
      chk("mid_rst_no_ack", bus.ack_o, 0);
    end
    @(negedge clk); rst_n = 1'b1;
    a = '0;
    for (int t = 0; t < 20; t++) begin
      @(posedge clk); #1;
      if (bus.grant_o != '0) begin a = bus.grant_o; break; end
    end
    chk("mid_first_grant", a, 4'b0001);
    bus.req_i = '0;
    wait_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end
endmodule
